mano_req_encoder: RTL and testbench

Sequential request encoder/arbiter for the Mano datapath: collects up to seven one-hot request lines, latches them as pending, and presents one winner at a time as a 3-bit code with a valid/ack handshake. Code k (1..7) names line k-1; code 0 means no grant. Feeding `code` into the team's 3-to-8 decoder reproduces `grant`. It sits in front of the control unit's decoded-line consumers, for example the interrupt/IO service select.

---
 rtl/mano_req_encoder.sv | 151 +++++++++++++++
 tb/tb_mano_req_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mano_req_encoder.sv
// mano_req_encoder
//   Sequential request encoder/arbiter for the Mano datapath. Up to seven
//   request lines are latched as pending and one winner at a time is
//   presented as a 3-bit code (k = line k-1, 0 = no grant) with a
//   valid/ack handshake. An optional wait timeout withdraws an
//   unacknowledged grant.
//
// Parameters
//   TIMEOUT  cycles a grant may wait for ack (0 = never withdrawn), 0..255
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [6:0] request lines (level or single-cycle pulse)
//   ack    in   consumer accepts current grant (ignored while valid=0)
//   code   out  [2:0] registered grant code, 0 when idle
//   valid  out  registered, code/grant meaningful
//   grant  out  [6:0] one-hot decode of code, zero when idle
//   pend   out  [6:0] pending register
//   tmo    out  one-cycle pulse after a grant is withdrawn by timeout
//
// Build option
//   MANO_REQ_RR_EN  defined: round-robin priority starting after the last
//                   acked line; undefined: fixed priority, line 0 highest.

module mano_req_encoder #(
    parameter int TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] req,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [6:0] grant,
    output logic [6:0] pend,
    output logic       tmo
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic       TMO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [6:0] cand;
    logic [6:0] clr;
    logic [2:0] win_idx;
    logic       win_any;

    // Requests arriving this cycle are eligible immediately, giving the
    // single-cycle request-to-grant latency from IDLE.
    assign cand = pend | req;

    // Only an acknowledged grant retires its pending bit.
    assign clr = (state == GRANT && ack) ? grant : 7'd0;

`ifdef MANO_REQ_RR_EN
    // Line index searched first; one past the most recently acked line.
    logic [2:0] ptr;
    int         pos;

    always_comb begin
        win_idx = 3'd0;
        win_any = 1'b0;
        pos     = 0;
        for (int i = 0; i < 7; i++) begin
            pos = int'(ptr) + i;
            if (pos >= 7) begin
                pos = pos - 7;
            end
            if (!win_any && cand[3'(pos)]) begin
                win_any = 1'b1;
                win_idx = 3'(pos);
            end
        end
    end

    // code holds line+1, which is exactly the next line to search from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 3'd0;
        end else if (state == GRANT && ack) begin
            ptr <= (code == 3'd7) ? 3'd0 : code;
        end
    end
`else
    always_comb begin
        win_idx = 3'd0;
        win_any = |cand;
        // Descending scan so the lowest set line is the last one written.
        for (int i = 6; i >= 0; i--) begin
            if (cand[3'(i)]) begin
                win_idx = 3'(i);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            code     <= 3'd0;
            valid    <= 1'b0;
            grant    <= 7'd0;
            pend     <= 7'd0;
            tmo      <= 1'b0;
            wait_cnt <= 8'd0;
        end else begin
            tmo  <= 1'b0;
            // New requests override the clear so a line re-requested on its
            // own ack edge stays pending.
            pend <= (pend & ~clr) | req;
            case (state)
                IDLE: begin
                    if (win_any) begin
                        state    <= GRANT;
                        valid    <= 1'b1;
                        code     <= win_idx + 3'd1;
                        grant    <= 7'd1 << win_idx;
                        wait_cnt <= 8'd0;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        code  <= 3'd0;
                        grant <= 7'd0;
                    end else if (TMO_EN && wait_cnt == TMO_LAST) begin
                        state <= IDLE;
                        valid <= 1'b0;
                        code  <= 3'd0;
                        grant <= 7'd0;
                        tmo   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mano_req_encoder.sv
module tb_mano_req_encoder;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] req = 7'd0;
    logic       ack = 1'b0;
    logic [2:0] code;
    logic       valid;
    logic [6:0] grant;
    logic [6:0] pend;
    logic       tmo;

    int total = 0;
    int bad   = 0;

    mano_req_encoder #(.TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .grant (grant),
        .pend  (pend),
        .tmo   (tmo)
    );

    always #5 clk = ~clk;

    // Behavioural reference: granted line number (-1 = none), cycles waited,
    // next line to search from, and a per-line pending flag.
    int m_line;
    int m_wait;
    int m_ptr;
    bit m_pend [7];
    bit m_tmo;

    function automatic logic [6:0] m_pend_vec();
        logic [6:0] v;
        v = 7'd0;
        for (int j = 0; j < 7; j++) if (m_pend[j]) v = v | (7'd1 << j);
        return v;
    endfunction

    task automatic model_reset();
        m_line = -1;
        m_wait = 0;
        m_ptr  = 0;
        m_tmo  = 0;
        for (int j = 0; j < 7; j++) m_pend[j] = 0;
    endtask

    function automatic int m_pick(input logic [6:0] r);
        int start;
        int j;
`ifdef MANO_REQ_RR_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < 7; k++) begin
            j = (start + k) % 7;
            if (m_pend[j] || r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_cycle(input logic [6:0] r, input logic a);
        int w;
        m_tmo = 0;
        if (m_line < 0) begin
            w = m_pick(r);
            if (w >= 0) begin
                m_line = w;
                m_wait = 0;
            end
        end else if (a) begin
            m_pend[m_line] = 0;
            m_ptr  = (m_line + 1) % 7;
            m_line = -1;
        end else if (m_wait == T - 1) begin
            m_line = -1;
            m_tmo  = 1;
        end else begin
            m_wait++;
        end
        for (int j = 0; j < 7; j++) if (r[j]) m_pend[j] = 1;
    endtask

    // Drive one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic step(input logic [6:0] r, input logic a);
        req = r;
        ack = a;
        model_cycle(r, a);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string nm);
        chk({nm, ".code"},  {29'd0, code},  (m_line < 0) ? 0 : m_line + 1);
        chk({nm, ".valid"}, {31'd0, valid}, (m_line < 0) ? 0 : 1);
        chk({nm, ".grant"}, {25'd0, grant}, (m_line < 0) ? 0 : (1 << m_line));
        chk({nm, ".pend"},  {25'd0, pend},  {25'd0, m_pend_vec()});
        chk({nm, ".tmo"},   {31'd0, tmo},   {31'd0, m_tmo});
    endtask

    typedef struct {
        logic [6:0] r;
        logic       a;
        logic [2:0] code;
        logic       valid;
        logic [6:0] pend;
        logic       tmo;
    } vec_t;

    vec_t tbl[$];
    int   exp_seq[6];
    int   got;
    logic [6:0] rr;
    logic       ra;

    initial begin
        // single request, ack on the second GRANT edge
        tbl.push_back('{7'b0000100, 1'b0, 3'd3, 1'b1, 7'b0000100, 1'b0});
        tbl.push_back('{7'b0000000, 1'b0, 3'd3, 1'b1, 7'b0000100, 1'b0});
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b0000000, 1'b0});
        tbl.push_back('{7'b0000000, 1'b0, 3'd0, 1'b0, 7'b0000000, 1'b0});
        // priority between lines 0 and 6
        tbl.push_back('{7'b1000001, 1'b0, 3'd1, 1'b1, 7'b1000001, 1'b0});
        tbl.push_back('{7'b1000001, 1'b1, 3'd0, 1'b0, 7'b1000001, 1'b0});
`ifdef MANO_REQ_RR_EN
        tbl.push_back('{7'b1000001, 1'b0, 3'd7, 1'b1, 7'b1000001, 1'b0});
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b0000001, 1'b0});
        tbl.push_back('{7'b0000000, 1'b0, 3'd1, 1'b1, 7'b0000001, 1'b0});
`else
        tbl.push_back('{7'b1000001, 1'b0, 3'd1, 1'b1, 7'b1000001, 1'b0});
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b1000000, 1'b0});
        tbl.push_back('{7'b0000000, 1'b0, 3'd7, 1'b1, 7'b1000000, 1'b0});
`endif
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b0000000, 1'b0});
        // request on the same edge its grant is acked: set wins
        tbl.push_back('{7'b0000100, 1'b0, 3'd3, 1'b1, 7'b0000100, 1'b0});
        tbl.push_back('{7'b0000100, 1'b1, 3'd0, 1'b0, 7'b0000100, 1'b0});
        tbl.push_back('{7'b0000000, 1'b0, 3'd3, 1'b1, 7'b0000100, 1'b0});
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b0000000, 1'b0});
        // ack while idle is ignored; held ack takes the first GRANT cycle
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b0000000, 1'b0});
        tbl.push_back('{7'b0010000, 1'b1, 3'd5, 1'b1, 7'b0010000, 1'b0});
        tbl.push_back('{7'b0000000, 1'b1, 3'd0, 1'b0, 7'b0000000, 1'b0});

        model_reset();
        #12;
        chk("rst.code",  {29'd0, code},  0);
        chk("rst.valid", {31'd0, valid}, 0);
        chk("rst.grant", {25'd0, grant}, 0);
        chk("rst.pend",  {25'd0, pend},  0);
        chk("rst.tmo",   {31'd0, tmo},   0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].a);
            chk($sformatf("tbl%0d.code", i),  {29'd0, code},  {29'd0, tbl[i].code});
            chk($sformatf("tbl%0d.valid", i), {31'd0, valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d.grant", i), {25'd0, grant},
                (tbl[i].code == 3'd0) ? 0 : (1 << (tbl[i].code - 3'd1)));
            chk($sformatf("tbl%0d.pend", i),  {25'd0, pend},  {25'd0, tbl[i].pend});
            chk($sformatf("tbl%0d.tmo", i),   {31'd0, tmo},   {31'd0, tbl[i].tmo});
        end

        // timeout: valid for exactly T cycles, tmo with IDLE, pend kept, re-grant
        step(7'b0100000, 1'b0);
        chk("to.first.code", {29'd0, code}, 6);
        for (int k = 1; k < T; k++) begin
            step(7'd0, 1'b0);
            chk($sformatf("to.hold%0d.valid", k), {31'd0, valid}, 1);
            chk($sformatf("to.hold%0d.tmo", k),   {31'd0, tmo},   0);
        end
        step(7'd0, 1'b0);
        chk("to.drop.valid", {31'd0, valid}, 0);
        chk("to.drop.code",  {29'd0, code},  0);
        chk("to.drop.tmo",   {31'd0, tmo},   1);
        chk("to.drop.pend",  {25'd0, pend},  7'b0100000);
        step(7'd0, 1'b0);
        chk("to.regrant.code", {29'd0, code}, 6);
        chk("to.regrant.tmo",  {31'd0, tmo},  0);
        step(7'd0, 1'b1);
        chk("to.ack.pend", {25'd0, pend}, 0);

        // asynchronous reset in the middle of a grant
        step(7'b0000100, 1'b0);
        chk("arst.pre.code", {29'd0, code}, 3);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.code",  {29'd0, code},  0);
        chk("arst.valid", {31'd0, valid}, 0);
        chk("arst.grant", {25'd0, grant}, 0);
        chk("arst.pend",  {25'd0, pend},  0);
        chk("arst.tmo",   {31'd0, tmo},   0);
        @(negedge clk);
        rst_n = 1'b1;
        step(7'd0, 1'b0);
        chk("arst.after1.valid", {31'd0, valid}, 0);
        step(7'd0, 1'b0);
        chk("arst.after2.valid", {31'd0, valid}, 0);

        // priority order with three lines held and every grant acked
`ifdef MANO_REQ_RR_EN
        exp_seq = '{1, 2, 4, 1, 2, 4};
`else
        exp_seq = '{1, 1, 1, 1, 1, 1};
`endif
        got = 0;
        for (int k = 0; k < 12; k++) begin
            step(7'b0001011, 1'b1);
            if (valid) begin
                if (got < 6) chk($sformatf("order%0d.code", got), {29'd0, code}, exp_seq[got]);
                got++;
            end
        end
        chk("order.count", got, 6);

        // randomized traffic against the reference model
        for (int k = 0; k < 3000; k++) begin
            rr = 7'd0;
            for (int j = 0; j < 7; j++) if ($urandom_range(7, 0) == 0) rr[j] = 1'b1;
            case ((k / 500) % 3)
                0:       ra = ($urandom_range(1, 0) == 0);
                1:       ra = ($urandom_range(7, 0) == 0);
                default: ra = ($urandom_range(3, 0) != 0);
            endcase
            step(rr, ra);
            chk_model($sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
